// File: rtl/eqn_serial_cmp_amisha_pkg.sv
// Shared definitions for the serial magnitude/equality comparator.
//   state_t     : FSM encoding (IDLE=0, CMP=1, DONE=2)
//   RES_*       : one-hot result encoding, bit order {lt, gt, eq}
//   cnt_width   : slice counter width, never narrower than one bit
//   res_from_gt : one-hot result for an unequal slice
package eqn_serial_cmp_amisha_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_EQ   = 3'b001;
  localparam logic [2:0] RES_GT   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b100;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // An unequal slice is either greater or less, so one bit picks the code.
  function automatic logic [2:0] res_from_gt(input logic gt);
    return gt ? RES_GT : RES_LT;
  endfunction

endpackage

// File: rtl/eqn_serial_cmp_amisha_slice_cmp.sv
// Combinational unsigned compare of one SLICE-bit slice.
//   x, y : slice operands
//   eq   : x == y
//   gt   : x >  y (unsigned)
// Equality is built from per-bit XNOR cells, the same structure as the
// old 1-bit eq unit, reduced with an AND.
module eqn_serial_cmp_amisha_slice_cmp #(
  parameter int SLICE = 2
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  output logic             eq,
  output logic             gt
);

  logic [SLICE-1:0] bit_eq;

  generate
    for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
      assign bit_eq[gi] = ~(x[gi] ^ y[gi]);
    end
  endgenerate

  assign eq = &bit_eq;
  assign gt = (x > y);

endmodule

// File: rtl/eqn_serial_cmp_amisha.sv
// Multi-cycle unsigned magnitude/equality comparator, MSB slice first.
//   clk_amisha   : clock, rising edge
//   rst_n_amisha : synchronous active-low reset
//   start_amisha : request, only looked at in IDLE
//   a_amisha     : operand A, captured on accepted start
//   b_amisha     : operand B, captured on accepted start
//   busy_amisha  : high while slices are being compared
//   done_amisha  : one-cycle pulse, result flags valid
//   aeqb_amisha  : A == B
//   agtb_amisha  : A >  B
//   altb_amisha  : A <  B
// Result flags are registered; they are set on entry to DONE and held
// until the next accepted start clears them.
module eqn_serial_cmp_amisha
  import eqn_serial_cmp_amisha_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SLICE      = 2,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk_amisha,
  input  logic             rst_n_amisha,
  input  logic             start_amisha,
  input  logic [WIDTH-1:0] a_amisha,
  input  logic [WIDTH-1:0] b_amisha,
  output logic             busy_amisha,
  output logic             done_amisha,
  output logic             aeqb_amisha,
  output logic             agtb_amisha,
  output logic             altb_amisha
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = cnt_width(NSLICE);
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);
  localparam bit EE_ON = (EARLY_EXIT != 0);

  generate
    if ((SLICE < 1) || (WIDTH < SLICE) || ((WIDTH % SLICE) != 0)) begin : g_bad_cfg
      $error("eqn_serial_cmp_amisha: WIDTH must be a non-zero multiple of SLICE");
    end
  endgenerate

  state_t            state_reg;
  state_t            state_next;
  logic [WIDTH-1:0]  a_sh_reg;
  logic [WIDTH-1:0]  b_sh_reg;
  logic [CW-1:0]     cnt_reg;
  logic              seen_reg;      // an unequal slice has already been found
  logic              first_gt_reg;  // direction of that first unequal slice
  logic [2:0]        res_reg;       // {lt, gt, eq}

  logic              slice_eq;
  logic              slice_gt;
  logic              last_slice;
  logic              exit_now;
  logic [2:0]        final_res;

  // Only the top slice is ever examined; the operands shift up under it.
  eqn_serial_cmp_amisha_slice_cmp #(
    .SLICE (SLICE)
  ) u_slice_cmp (
    .x  (a_sh_reg[WIDTH-1 -: SLICE]),
    .y  (b_sh_reg[WIDTH-1 -: SLICE]),
    .eq (slice_eq),
    .gt (slice_gt)
  );

  assign last_slice = (cnt_reg == LAST);
  assign exit_now   = last_slice || (EE_ON && !slice_eq);

  // The first difference decides the magnitude; later slices cannot change it.
  always_comb begin
    final_res = RES_EQ;
    if (EE_ON && !slice_eq) begin
      final_res = res_from_gt(slice_gt);
    end else if (seen_reg) begin
      final_res = res_from_gt(first_gt_reg);
    end else if (!slice_eq) begin
      final_res = res_from_gt(slice_gt);
    end
  end

  // State register
  always_ff @(posedge clk_amisha) begin
    if (!rst_n_amisha) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start_amisha) state_next = CMP;
      CMP:     if (exit_now)     state_next = DONE;
      DONE:                      state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy_amisha = (state_reg == CMP);
    done_amisha = (state_reg == DONE);
    aeqb_amisha = res_reg[0];
    agtb_amisha = res_reg[1];
    altb_amisha = res_reg[2];
  end

  // Datapath: operand shifters, slice counter, sticky first difference, result.
  always_ff @(posedge clk_amisha) begin
    if (!rst_n_amisha) begin
      a_sh_reg     <= '0;
      b_sh_reg     <= '0;
      cnt_reg      <= '0;
      seen_reg     <= 1'b0;
      first_gt_reg <= 1'b0;
      res_reg      <= RES_NONE;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start_amisha) begin
            a_sh_reg     <= a_amisha;
            b_sh_reg     <= b_amisha;
            cnt_reg      <= '0;
            seen_reg     <= 1'b0;
            first_gt_reg <= 1'b0;
            res_reg      <= RES_NONE;
          end
        end
        CMP: begin
          if (exit_now) begin
            res_reg <= final_res;
          end else begin
            a_sh_reg <= a_sh_reg << SLICE;
            b_sh_reg <= b_sh_reg << SLICE;
            cnt_reg  <= cnt_reg + CW'(1);
            if (!slice_eq && !seen_reg) begin
              seen_reg     <= 1'b1;
              first_gt_reg <= slice_gt;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
